// File: rtl/sp_ram_fifo_ctrl_if.sv
// FIFO-side handshake and status bundle for sp_ram_fifo_ctrl.
// The slave modport is the controller, and the master modport is the producer/consumer.
interface sp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller that drives an external single-port RAM with 1-cycle read latency.
// A pop takes the RAM port ahead of a push, and the deferred writer retries.
module sp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  sp_ram_fifo_ctrl_if.slave     bus,
  output logic [DATA_WIDTH-1:0] ram_d,
  output logic [ADDR_WIDTH-1:0] ram_adr,
  output logic                  ram_wre,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  rd_valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic empty_w, full_w, pop_acc, push_acc, wr_ready_w;

  assign empty_w    = (count_reg == '0);
  assign full_w     = (count_reg == DEPTH_CNT);
  // RST_N gating keeps the RAM port idle and refuses pushes while reset is held.
  assign pop_acc    = RST_N & bus.rd_en & ~empty_w;
  assign wr_ready_w = RST_N & ~full_w & ~pop_acc;
  assign push_acc   = bus.wr_en & wr_ready_w;

  always_comb begin
    ram_wre = 1'b0;
    ram_adr = rd_ptr_reg;
    ram_d   = bus.wr_data;
    if (push_acc) begin
      ram_wre = 1'b1;
      ram_adr = wr_ptr_reg;
    end
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop_acc) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next  = count_reg - 1'b1;
    end else if (push_acc) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
      count_next  = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      rd_valid_reg  <= pop_acc;
      overflow_reg  <= bus.wr_en & full_w & ~pop_acc;
      underflow_reg <= bus.rd_en & empty_w;
    end
  end

  assign bus.wr_ready  = wr_ready_w;
  assign bus.rd_data   = ram_q;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed and random checks of sp_ram_fifo_ctrl against a queue-based FIFO model,
// with a behavioural single-port RAM attached.
module tb_sp_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] ram_d, ram_q;
  logic [AW-1:0] ram_adr;
  logic          ram_wre;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [$];
  logic [AW-1:0] wr_idx, rd_idx;

  sp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .ram_d   (ram_d),
    .ram_adr (ram_adr),
    .ram_wre (ram_wre),
    .ram_q   (ram_q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_wre) mem[ram_adr] <= ram_d;
    else         ram_q <= mem[ram_adr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; drives one cycle, checks both sides of the rising edge,
  // and returns on the next falling edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    bit            exp_pop, exp_push, was_full, was_empty;
    logic [DW-1:0] exp_word;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    was_full  = (q.size() == (1 << AW));
    was_empty = (q.size() == 0);
    exp_pop   = re && !was_empty;
    exp_push  = we && !exp_pop && !was_full;
    exp_word  = '0;
    #1;
    chk("wr_ready", 32'(bus.wr_ready), 32'(!exp_pop && !was_full));
    chk("ram_wre", 32'(ram_wre), 32'(exp_push));
    chk("ram_adr", 32'(ram_adr), 32'(exp_push ? wr_idx : rd_idx));
    if (exp_push) chk("ram_d", 32'(ram_d), 32'(wd));
    @(posedge CLK);
    #1;
    if (exp_pop) begin
      exp_word = q.pop_front();
      rd_idx++;
    end
    if (exp_push) begin
      q.push_back(wd);
      wr_idx++;
    end
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_pop));
    if (exp_pop) chk("rd_data", 32'(bus.rd_data), 32'(exp_word));
    chk("overflow", 32'(bus.overflow), 32'(we && was_full && !exp_pop));
    chk("underflow", 32'(bus.underflow), 32'(re && was_empty));
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == (1 << AW)));
    $display("step we=%0b wd=%02h re=%0b -> count=%0d rd_valid=%0b rd_data=%02h ovf=%0b unf=%0b",
             we, wd, re, bus.count, bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow);
    @(negedge CLK);
  endtask

  task automatic check_reset_state();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
    chk("rst_ram_wre", 32'(ram_wre), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_ram_adr", 32'(ram_adr), 32'd0);
    q.delete();
    wr_idx = '0;
    rd_idx = '0;
  endtask

  initial begin
    RST_N       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    bus.rd_en   = 1'b1;
    #3;
    check_reset_state();
    @(negedge CLK);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // Fill with A1..A8, then drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++)  step(1'b0, 8'h00, 1'b1);

    // Fill to full, overflow attempt, then simultaneous request while full.
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b1, 8'hDD, 1'b1);
    step(1'b1, 8'hCC, 1'b0);

    // Drain, underflow attempt, and simultaneous request while empty.
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hBB, 1'b1);

    // Random traffic crosses the pointer wrap several times.
    for (int i = 0; i < 120; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset while a pop result is being presented.
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    RST_N = 1'b0;
    #1;
    check_reset_state();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_ram_fifo_ctrl.md
SP_RAM_FIFO_CTRL -- requirements
Module: sp_ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data words and of the RAM data port.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM address width; FIFO depth = 2**ADDR_WIDTH (16).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 WR_EN  input  1  push request.
REQ-006 WR_DATA  input  DATA_WIDTH  push data.
REQ-007 WR_READY  output  1  push accepted this cycle when WR_EN=1 and WR_READY=1.
REQ-008 RD_EN  input  1  pop request; accepted when RD_EN=1 and EMPTY=0.
REQ-009 RD_DATA  output  DATA_WIDTH  popped word; driven from RAM_Q.
REQ-010 RD_VALID  output  1  RD_DATA valid this cycle.
REQ-011 FULL  output  1  COUNT == 2**ADDR_WIDTH.
REQ-012 EMPTY  output  1  COUNT == 0.
REQ-013 COUNT  output  ADDR_WIDTH+1  stored word count.
REQ-014 OVERFLOW  output  1  one-cycle pulse, push attempted while full.
REQ-015 UNDERFLOW  output  1  one-cycle pulse, pop attempted while empty.
REQ-016 RAM_D  output  DATA_WIDTH  to single-port RAM D.
REQ-017 RAM_ADR  output  ADDR_WIDTH  to RAM ADR.
REQ-018 RAM_WRE  output  1  to RAM WRE (1 = write).
REQ-019 RAM_Q  input  DATA_WIDTH  from RAM Q.

Function
REQ-020 The RAM SHALL be treated as single-port: write of RAM_D to RAM_ADR on rising CLK when RAM_WRE=1; otherwise RAM_Q = mem[RAM_ADR] registered on rising CLK (1-cycle read latency).
REQ-021 Pop accept (pop_acc) = RD_EN & ~EMPTY; push accept (push_acc) = WR_EN & WR_READY.
REQ-022 WR_READY = ~FULL & ~pop_acc (combinational); reads have priority over writes for the single RAM port.
REQ-023 pop_acc SHALL drive RAM_ADR = rd_ptr, RAM_WRE = 0; else push_acc SHALL drive RAM_ADR = wr_ptr, RAM_WRE = 1, RAM_D = WR_DATA; else RAM_WRE = 0, RAM_ADR = rd_ptr.
REQ-024 At most one of push_acc/pop_acc SHALL be true per cycle.
REQ-025 rd_ptr and wr_ptr are ADDR_WIDTH-bit, increment by 1 on pop_acc/push_acc, wrap 15 -> 0 modulo 2**ADDR_WIDTH.
REQ-026 COUNT +1 on push_acc, -1 on pop_acc, unchanged otherwise; never exceeds 16 or goes below 0.
REQ-027 RD_VALID SHALL be registered pop_acc (asserted exactly the cycle after an accepted pop); RD_DATA = RAM_Q.
REQ-028 Pop latency: RD_EN accepted at edge N -> RD_VALID=1 with data during cycle N+1.
REQ-029 Push-to-pop: a word pushed at edge N is poppable from cycle N+1 (EMPTY deasserts after edge N).
REQ-030 OVERFLOW SHALL pulse for 1 cycle after an edge where WR_EN=1 and FULL=1 and pop_acc=0; no write performed.
REQ-031 Push deferred due to pop priority (FULL=0, pop_acc=1) SHALL NOT raise OVERFLOW; WR_EN holder retries.
REQ-032 UNDERFLOW SHALL pulse for 1 cycle after an edge where RD_EN=1 and EMPTY=1; pointers and COUNT unchanged.
REQ-033 Full and both requested: pop accepted, push refused, COUNT 16 -> 15, no OVERFLOW.
REQ-034 Empty and both requested: push accepted, UNDERFLOW pulses, COUNT 0 -> 1.
REQ-035 Data SHALL emerge in push order (FIFO), including across pointer wrap.

Reset
REQ-036 RST_N=0 SHALL immediately set rd_ptr=0, wr_ptr=0, COUNT=0, EMPTY=1, FULL=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0, and force RAM_WRE=0, WR_READY=0.
REQ-037 Reset mid-operation SHALL discard a pending RD_VALID and all stored words; RAM contents are not cleared and are treated as undefined.
REQ-038 First push/pop SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-039 Reset then push 8'hA1..8'hA8 (8 cycles) -> COUNT=8, RAM_WRE=1 on ADR 0..7, EMPTY=0, FULL=0.
REQ-040 Then pop 8 cycles -> RD_VALID on 8 consecutive cycles, each one after its pop, RD_DATA A1..A8 in order, EMPTY=1.
REQ-041 Push 16 words -> FULL=1, WR_READY=0; 17th push -> OVERFLOW one cycle, COUNT stays 16.
REQ-042 FULL with WR_EN=RD_EN=1 one cycle -> pop of oldest word, COUNT=15, no OVERFLOW; next cycle push accepted at wrapped ADR.
REQ-043 Pop when empty -> UNDERFLOW one cycle, RD_VALID=0; 20 push/pop cycles crossing ptr 15->0 -> order preserved.
REQ-044 Assert RST_N=0 mid-stream with pop pending -> RD_VALID, COUNT, pointers 0 immediately, EMPTY=1.
